// File: rtl/memory_dump_streamer.sv
// Test-run controller: boots and runs the core, then freezes it and streams memory to the UART.
// Define DUMP_CHECKSUM_EN to append an 8-bit modular sum of all data bytes to the stream.
module memory_dump_streamer #(
   parameter int unsigned WORD_WIDTH        = 32,
   parameter int unsigned NUM_PAGES         = 13,
   parameter int unsigned PAGE_WORDS        = 16,
   parameter logic [31:0] BASE_ADDRESS      = 32'h0,
   parameter int unsigned CORE_RESET_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 25000000,
   parameter int unsigned READ_LATENCY      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  finish_execution,
   output logic                  enable_clk,
   output logic                  reset_core,
   output logic                  bus_select,
   output logic                  memory_read,
   output logic [31:0]           address,
   input  logic [WORD_WIDTH-1:0] read_data,
   input  logic                  uart_full,
   output logic                  uart_write,
   output logic [7:0]            uart_data,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam int unsigned NumWords = NUM_PAGES * PAGE_WORDS;
   localparam int unsigned Bytes    = WORD_WIDTH / 8;
   localparam int unsigned IdxW     = $clog2(NumWords) + 1;
   localparam int unsigned BootW    = $clog2(CORE_RESET_CYCLES + 1);
   localparam int unsigned LatW     = $clog2(READ_LATENCY + 1);

   typedef enum logic [2:0] {
      StBoot     = 3'd0,
      StRun      = 3'd1,
      StRead     = 3'd2,
      StWait     = 3'd3,
      StSend     = 3'd4,
      StDone     = 3'd5
`ifdef DUMP_CHECKSUM_EN
      ,
      StChecksum = 3'd6
`endif
   } state_e;

   state_e                state_q;
   logic [BootW-1:0]      boot_cnt_q;
   logic [31:0]           wd_cnt_q;
   logic [IdxW-1:0]       idx_q;
   logic [LatW-1:0]       lat_cnt_q;
   logic [3:0]            byte_cnt_q;
   logic [WORD_WIDTH-1:0] shift_q;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   logic wd_expired;
   logic last_byte;
   logic last_word;

   assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
   assign last_byte  = (byte_cnt_q == 4'(Bytes - 1));
   assign last_word  = (idx_q == IdxW'(NumWords - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StBoot;
         boot_cnt_q  <= '0;
         wd_cnt_q    <= '0;
         idx_q       <= '0;
         lat_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
         enable_clk  <= 1'b0;
         reset_core  <= 1'b1;
         bus_select  <= 1'b0;
         memory_read <= 1'b0;
         address     <= BASE_ADDRESS;
         uart_write  <= 1'b0;
         uart_data   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state_q)
            StBoot: begin
               if (boot_cnt_q == BootW'(CORE_RESET_CYCLES - 1)) begin
                  state_q    <= StRun;
                  reset_core <= 1'b0;
                  enable_clk <= 1'b1;
               end else begin
                  boot_cnt_q <= boot_cnt_q + BootW'(1);
               end
            end
            StRun: begin
               // Finish has priority over a coincident watchdog expiry.
               if (finish_execution || wd_expired) begin
                  state_q     <= StRead;
                  enable_clk  <= 1'b0;
                  bus_select  <= 1'b1;
                  busy        <= 1'b1;
                  memory_read <= 1'b1;
                  address     <= BASE_ADDRESS;
                  idx_q       <= '0;
                  timeout     <= ~finish_execution;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 32'd1;
               end
            end
            StRead: begin
               memory_read <= 1'b0;
               lat_cnt_q   <= LatW'(1);
               state_q     <= StWait;
            end
            StWait: begin
               if (lat_cnt_q == LatW'(READ_LATENCY)) begin
                  shift_q    <= read_data;
                  byte_cnt_q <= '0;
                  state_q    <= StSend;
               end else begin
                  lat_cnt_q <= lat_cnt_q + LatW'(1);
               end
            end
            StSend: begin
               // The cycle after a pulse is the gap that lets the FIFO full flag settle.
               if (uart_write) begin
                  uart_write <= 1'b0;
                  if (last_byte) begin
                     if (last_word) begin
`ifdef DUMP_CHECKSUM_EN
                        state_q <= StChecksum;
`else
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                     end else begin
                        idx_q       <= idx_q + IdxW'(1);
                        address     <= address + 32'(Bytes);
                        memory_read <= 1'b1;
                        state_q     <= StRead;
                     end
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 4'd1;
                     shift_q    <= shift_q >> 8;
                  end
               end else if (!uart_full) begin
                  uart_write <= 1'b1;
                  uart_data  <= shift_q[7:0];
`ifdef DUMP_CHECKSUM_EN
                  csum_q     <= csum_q + shift_q[7:0];
`endif
               end
            end
`ifdef DUMP_CHECKSUM_EN
            StChecksum: begin
               if (uart_write) begin
                  uart_write <= 1'b0;
                  state_q    <= StDone;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (!uart_full) begin
                  uart_write <= 1'b1;
                  uart_data  <= csum_q;
               end
            end
`endif
            StDone: begin
               state_q <= StDone;
            end
            default: begin
               state_q <= StBoot;
            end
         endcase
      end
   end

endmodule
